// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte producers.
// Latency: uart_start rises 1 cycle after req is seen; grant_ack pulses 1 cycle after uart_busy falls.
// Backpressure: no grant while uart_busy is high; requesters hold req and data until their grant_ack.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int n             = 8,
    parameter int START_TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*n-1:0]         req_data,
    output logic [NREQ-1:0]           grant_ack,
    output logic                      timeout_err,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   active_id,
    output logic                      uart_start,
    output logic [n-1:0]              uart_data,
    input  logic                      uart_busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(START_TIMEOUT);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        ACK
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    last, last_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IDW-1:0]    id_nxt;
    logic [n-1:0]      data_nxt;
    logic              start_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic              to_nxt;
    logic              busy_nxt;

    logic              win_found;
    logic [IDW-1:0]    win_id;
    logic [IDW-1:0]    cand;

    // Round-robin pick: scan from the requester after the last one served.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state and next-output logic for the grant / start / wait / ack sequence.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        id_nxt    = active_id;
        data_nxt  = uart_data;
        start_nxt = uart_start;
        ack_nxt   = '0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A busy UART here is a frame we did not start; wait for it to end.
                if (win_found && !uart_busy) begin
                    id_nxt    = win_id;
                    data_nxt  = req_data[int'(win_id)*n +: n];
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                if (uart_busy) begin
                    start_nxt = 1'b0;
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_MAX) begin
                    // Give up; the requester goes to the back of the rotation.
                    start_nxt = 1'b0;
                    to_nxt    = 1'b1;
                    last_nxt  = active_id;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    ack_nxt[active_id] = 1'b1;
                    state_nxt          = ACK;
                end
            end
            ACK: begin
                last_nxt  = active_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= LAST_RST;
            cnt         <= '0;
            active_id   <= '0;
            uart_data   <= '0;
            uart_start  <= 1'b0;
            grant_ack   <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            cnt         <= cnt_nxt;
            active_id   <= id_nxt;
            uart_data   <= data_nxt;
            uart_start  <= start_nxt;
            grant_ack   <= ack_nxt;
            timeout_err <= to_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed sequences, a priority table and a randomized run
// checked against a transaction-level model of the grant/start/ack rules.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int NB   = 8;
    localparam int TMO  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant_ack;
    logic        timeout_err;
    logic        busy;
    logic [1:0]  active_id;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .n(NB), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant_ack(grant_ack), .timeout_err(timeout_err), .busy(busy),
        .active_id(active_id), .uart_start(uart_start), .uart_data(uart_data),
        .uart_busy(uart_busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int tick_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- UART transmitter model ----------------
    bit u_en = 0, u_rand = 0, u_stray = 0;
    int u_d = 1, u_h = 1, u_sc = 0, u_left = 0;
    int last_fall = -1;

    task automatic uart_step();
        if (!u_en) return;
        if (u_left > 0) begin
            u_left--;
            if (u_left == 0) begin
                uart_busy = 1'b0;
                last_fall = tick_no;
            end
        end else if (uart_start) begin
            if (u_sc == 0 && u_rand)
                u_d = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 4));
            u_sc++;
            if (u_sc >= u_d) begin
                if (u_rand) u_h = $urandom_range(1, 8);
                uart_busy = 1'b1;
                u_left    = u_h;
                u_sc      = 0;
            end
        end else begin
            u_sc = 0;
            if (u_stray && $urandom_range(0, 40) == 0) begin
                uart_busy = 1'b1;
                u_left    = $urandom_range(1, 4);
            end
        end
    endtask

    // ---------------- reference model ----------------
    bit        m_en = 0;
    int        m_phase = 0;   // 0 free, 1 start raised, 2 frame in flight, 3 post-ack cycle
    int        m_last = 3, m_win = 0, m_age = 0;

    function automatic int rr(input int lst, input logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (lst + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // rs/ds/bs are the input values the DUT saw at the edge just taken.
    task automatic monitor(input logic [3:0] rs, input logic [31:0] ds, input logic bs);
        case (m_phase)
            0: begin
                if (rs != 0 && !bs) begin
                    m_win = rr(m_last, rs);
                    chk("rnd_grant_start", uart_start, 1);
                    chk("rnd_grant_id", active_id, m_win);
                    chk("rnd_grant_data", uart_data, ds[m_win*8 +: 8]);
                    m_age   = 0;
                    m_phase = 1;
                end else begin
                    chk("rnd_idle_quiet", {uart_start, busy, grant_ack, timeout_err}, 0);
                end
            end
            1: begin
                m_age++;
                if (bs) begin
                    chk("rnd_start_drop", {uart_start, busy, timeout_err}, 3'b010);
                    m_phase = 2;
                end else if (m_age == TMO + 1) begin
                    chk("rnd_timeout", {uart_start, timeout_err, busy}, 3'b010);
                    chk("rnd_timeout_noack", grant_ack, 0);
                    m_last  = m_win;
                    m_phase = 0;
                end else begin
                    chk("rnd_start_hold", {uart_start, busy, timeout_err, grant_ack}, 7'b1100000);
                end
            end
            2: begin
                if (!bs) begin
                    chk("rnd_ack", {busy, grant_ack, timeout_err}, {1'b1, 4'(4'b1 << m_win), 1'b0});
                    m_last  = m_win;
                    m_phase = 3;
                end else begin
                    chk("rnd_frame", {uart_start, busy, grant_ack}, 6'b010000);
                end
            end
            default: begin
                chk("rnd_gap", {uart_start, busy, grant_ack, timeout_err}, 0);
                m_phase = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        if (m_en) monitor(req, req_data, uart_busy);
        uart_step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        u_left    = 0;
        u_sc      = 0;
        u_rand    = 0;
        u_stray   = 0;
        uart_busy = 1'b0;
        last_fall = -1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         lst;
        logic [3:0] r;
        int         exp;
    } prio_t;

    prio_t      tbl[8];
    logic [7:0] cur[4];
    int         exp_ord[6] = '{0, 1, 2, 3, 0, 1};

    task automatic repack();
        for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = cur[i];
    endtask

    initial begin
        int  nstart, nack, ack_at, ng, nto, nbad;
        bit  got, prev_start;

        rst_n = 1'b0; req = '0; req_data = '0; uart_busy = 1'b0;
        tick();
        tick();
        chk("rst_start", uart_start, 0);
        chk("rst_data", uart_data, 0);
        chk("rst_ack", grant_ack, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", active_id, 0);
        rst_n = 1'b1;

        // Single request, UART busy 3 cycles after start for 20 cycles.
        u_en = 1; u_d = 3; u_h = 20;
        req = 4'b0001; req_data = 32'h000000A5;
        nstart = 0; nack = 0; ack_at = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_start) begin
                nstart++;
                chk("single_data", uart_data, 8'hA5);
            end
            if (grant_ack != 0) begin
                nack++;
                chk("single_ack_bits", grant_ack, 4'b0001);
                ack_at = tick_no;
                req    = '0;
            end
        end
        chk("single_start_cycles", nstart, 3);
        chk("single_ack_count", nack, 1);
        chk("single_ack_timing", ack_at, last_fall + 1);
        chk("single_busy_after", busy, 0);

        // Priority table: serve requester lst first, then present r.
        tbl[0] = '{1, 4'b0101, 2};
        tbl[1] = '{3, 4'b1111, 0};
        tbl[2] = '{0, 4'b1111, 1};
        tbl[3] = '{2, 4'b0011, 0};
        tbl[4] = '{0, 4'b0001, 0};
        tbl[5] = '{3, 4'b1000, 3};
        tbl[6] = '{2, 4'b1010, 3};
        tbl[7] = '{1, 4'b0011, 0};
        for (int t = 0; t < 8; t++) begin
            do_reset();
            u_en = 1; u_d = 1; u_h = 2;
            req_data = 32'h33323130;
            req = 4'(4'b1 << tbl[t].lst);
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                tick();
                if (grant_ack != 0) begin
                    chk("prio_setup_ack", grant_ack, 4'(4'b1 << tbl[t].lst));
                    req = tbl[t].r;
                    got = 1;
                end
            end
            if (!got) chk("prio_setup_timeout", 0, 1);
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                tick();
                if (uart_start) got = 1;
            end
            if (!got) chk("prio_grant_timeout", 0, 1);
            chk("prio_id", active_id, tbl[t].exp);
            chk("prio_data", uart_data, 8'h30 + 8'(tbl[t].exp));
        end

        // Fairness: all four requesting, each refreshes its byte when acked.
        do_reset();
        u_en = 1; u_d = 2; u_h = 3;
        for (int i = 0; i < NREQ; i++) cur[i] = 8'(8'h40 + 16 * i);
        repack();
        req = 4'b1111;
        ng = 0; prev_start = 0;
        for (int i = 0; i < 300 && ng < 6; i++) begin
            tick();
            if (uart_start && !prev_start) begin
                chk("fair_order", active_id, exp_ord[ng]);
                chk("fair_data", uart_data, cur[exp_ord[ng]]);
                ng++;
            end
            if (grant_ack != 0 && ng > 0) begin
                chk("fair_ack", grant_ack, 4'(4'b1 << exp_ord[ng-1]));
                cur[exp_ord[ng-1]] = cur[exp_ord[ng-1]] + 8'd1;
                repack();
            end
            prev_start = uart_start;
        end
        chk("fair_grants", ng, 6);

        // Start timeout: UART never answers.
        do_reset();
        u_en = 0; uart_busy = 1'b0;
        req_data = 32'h33323130;
        req = 4'b0011;
        nstart = 0; nto = 0; nack = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (uart_start) nstart++;
            if (grant_ack != 0) nack++;
            if (timeout_err) begin
                nto++;
                got = 1;
            end
        end
        chk("tmo_start_cycles", nstart, TMO + 1);
        chk("tmo_pulse", nto, 1);
        chk("tmo_no_ack", nack, 0);
        tick();
        chk("tmo_pulse_width", timeout_err, 0);
        chk("tmo_next_start", uart_start, 1);
        chk("tmo_next_id", active_id, 1);
        chk("tmo_next_data", uart_data, 8'h31);

        // Foreign frame in flight blocks the grant.
        do_reset();
        u_en = 0; uart_busy = 1'b1;
        req_data = 32'h000000C3;
        req = 4'b0001;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uart_start || busy) nbad++;
        end
        chk("blk_no_start", nbad, 0);
        uart_busy = 1'b0;
        tick();
        chk("blk_grant", uart_start, 1);
        chk("blk_data", uart_data, 8'hC3);

        // Reset while the frame is in flight.
        do_reset();
        u_en = 1; u_d = 1; u_h = 30;
        req_data = 32'h33323130;
        req = 4'b0100;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (uart_busy) got = 1;
        end
        if (!got) chk("rstmid_busy_timeout", 0, 1);
        tick(); tick(); tick();
        chk("rstmid_pre_busy", {busy, active_id}, 3'b110);
        rst_n = 1'b0;
        tick();
        chk("rstmid_start", uart_start, 0);
        chk("rstmid_ack", grant_ack, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_id", active_id, 0);
        rst_n = 1'b1;
        req = 4'b0010;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (uart_start) got = 1;
        end
        if (!got) chk("rstmid_grant_timeout", 0, 1);
        chk("rstmid_grant_after_fall", tick_no, last_fall + 1);
        chk("rstmid_grant_id", active_id, 1);

        // Randomized traffic against the reference model.
        do_reset();
        u_en = 1; u_rand = 1; u_stray = 1;
        m_last = 3; m_phase = 0; m_en = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (grant_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else req_data[i*8 +: 8] = 8'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req_data[i*8 +: 8] = 8'($urandom);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        m_en = 0;
        u_stray = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
